// File: rtl/raizing_sndcmd_fifo.sv
// raizing_sndcmd_fifo
// Command mailbox from the 68000 main CPU to the Z80 sound CPU. Bytes written
// by the 68000 are queued. The oldest byte is presented on SOUNDLATCH, and
// Z80INT is pulsed to announce it. Each Z80 acknowledge pops one entry. If no
// acknowledge arrives within 2^TO_W cycles of a pulse ending, the Z80 is
// interrupted again, so a missed IRQ cannot strand a command.
//
// Ports:
//   CLK96       sole clock
//   RESET96     asynchronous, active-high reset
//   CMD_WE      68000 write strobe (level; only the rising edge acts)
//   CMD_DIN     command byte, sampled in the CMD_WE rising-edge cycle
//   ACK         Z80 acknowledge (level; only the rising edge acts)
//   SOUNDLATCH  registered head-of-FIFO byte (holds its last value when empty)
//   Z80INT      interrupt pulse to the sound block
//   EMPTY/FULL  registered occupancy flags
//   COUNT       occupancy, 0..DEPTH
//   OVF         sticky overflow (a push was dropped)
//   WAIT_N      active-low backpressure to the 68000
//   FSM_STATE   IRQ FSM state, for observation only
//
// Build option: RAIZING_SNDCMD_BACKPRESSURE_EN
//   defined   - WAIT_N = ~FULL (registered). A write while full is held in a
//               one-entry pending slot and pushed once FULL clears. OVF stays 0.
//   undefined - WAIT_N is tied to 1. A write while full is dropped and OVF is set.
//
// Handshake: no valid/ready pair. A command is offered by a CMD_WE rising edge
// and consumed by an ACK rising edge. An ACK rising edge while the FIFO is
// empty is ignored. A push and a pop in the same cycle both take effect, even
// when the FIFO is full.

module raizing_sndcmd_fifo #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 8,
  parameter int GAP_LEN   = 16,
  parameter int TO_W      = 20
) (
  input  logic                   CLK96,
  input  logic                   RESET96,
  input  logic                   CMD_WE,
  input  logic [7:0]             CMD_DIN,
  input  logic                   ACK,
  output logic [7:0]             SOUNDLATCH,
  output logic                   Z80INT,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  output logic                   WAIT_N,
  output logic [1:0]             FSM_STATE
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PULSE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;

  logic          we_d;
  logic          ack_d;
  logic          we_re;
  logic          ack_re;
  logic          pop;
  logic          push;
  logic [7:0]    push_data;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [1:0]    state;
  logic [TW-1:0] tmr;
  logic [TO_W-1:0] to_cnt;

`ifdef RAIZING_SNDCMD_BACKPRESSURE_EN
  logic          pend_v;
  logic [7:0]    pend_d;
  logic          pend_set;
  logic          pend_clr;
`else
  logic          drop;
`endif

  assign we_re     = CMD_WE & ~we_d;
  assign ack_re    = ACK & ~ack_d;
  assign pop       = ack_re & (COUNT != '0);
  assign FSM_STATE = state;

  // Push arbitration. A pop in the same cycle makes room, so a full FIFO
  // still accepts the write (pop first, then push).
  always_comb begin
    push      = 1'b0;
    push_data = CMD_DIN;
`ifdef RAIZING_SNDCMD_BACKPRESSURE_EN
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    if (pend_v) begin
      // A held write goes in on the first cycle FULL is low. Any new edge
      // that arrives while it is held is ignored, because WAIT_N is low.
      if (!FULL) begin
        push      = 1'b1;
        push_data = pend_d;
        pend_clr  = 1'b1;
      end
    end else if (we_re) begin
      if (FULL && !pop) pend_set = 1'b1;
      else              push     = 1'b1;
    end
`else
    drop = 1'b0;
    if (we_re) begin
      if (FULL && !pop) drop = 1'b1;
      else              push = 1'b1;
    end
`endif
    count_nxt = COUNT + CW'(push) - CW'(pop);
  end

  // Storage is not reset. The pointers and COUNT alone decide which entries
  // are live.
  always_ff @(posedge CLK96) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      we_d       <= 1'b0;
      ack_d      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      COUNT      <= '0;
      EMPTY      <= 1'b1;
      FULL       <= 1'b0;
      SOUNDLATCH <= 8'h00;
    end else begin
      we_d  <= CMD_WE;
      ack_d <= ACK;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == CW'(DEPTH));
      // Follows the registered pointer and count. The head therefore appears
      // one cycle after the write or pop that changed it.
      if (COUNT != '0) SOUNDLATCH <= mem[rd_ptr];
    end
  end

`ifdef RAIZING_SNDCMD_BACKPRESSURE_EN
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      pend_v <= 1'b0;
      pend_d <= 8'h00;
      WAIT_N <= 1'b1;
    end else begin
      if (pend_set) begin
        pend_v <= 1'b1;
        pend_d <= CMD_DIN;
      end else if (pend_clr) begin
        pend_v <= 1'b0;
      end
      WAIT_N <= (count_nxt != CW'(DEPTH));
    end
  end

  assign OVF = 1'b0;
`else
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) OVF <= 1'b0;
    else if (drop) OVF <= 1'b1;
  end

  assign WAIT_N = 1'b1;
`endif

  // IRQ FSM. Z80INT is a registered image of the PULSE state, so it rises one
  // cycle after the FSM enters PULSE and stays high for PULSE_LEN cycles. An
  // acknowledge during PULSE drops Z80INT on the next edge.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state  <= S_IDLE;
      tmr    <= '0;
      to_cnt <= '0;
      Z80INT <= 1'b0;
    end else begin
      Z80INT <= (state == S_PULSE) && !ack_re;
      case (state)
        S_IDLE: begin
          if (COUNT != '0) begin
            state <= S_PULSE;
            tmr   <= TW'(PULSE_LEN - 1);
          end
        end
        S_PULSE: begin
          if (ack_re) begin
            state <= S_GAP;
            tmr   <= TW'(GAP_LEN - 1);
          end else if (tmr == '0) begin
            state  <= S_WAIT_ACK;
            to_cnt <= '0;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack_re) begin
            state <= S_GAP;
            tmr   <= TW'(GAP_LEN - 1);
          end else if (COUNT == '0) begin
            // The queue was drained by an acknowledge seen outside this
            // state. There is nothing left to re-announce.
            state <= S_IDLE;
          end else if (&to_cnt) begin
            state <= S_PULSE;
            tmr   <= TW'(PULSE_LEN - 1);
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin // S_GAP
          if (tmr == '0) state <= S_IDLE;
          else           tmr   <= tmr - TW'(1);
        end
      endcase
    end
  end

endmodule
